// File: rtl/param_ram.sv
// param_ram: parametrised single-port synchronous RAM.
//
// Byte-enable writes, request/ready handshake, 1- or 2-cycle read pipeline with a
// valid strobe, and a sequencer that zero-fills the array after reset (optional) or
// on a clear pulse.
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     asynchronous active-high reset
//   en_i        request valid
//   r_i         request type: 1 = read, 0 = write
//   addr_i      request address
//   wdata_i     write data
//   be_i        per-byte write enables (ignored on reads)
//   clear_i     single-cycle zero-fill request
//   ready_o     request accepted this cycle when en_i && ready_o
//   rdata_o     read data, held between reads
//   rvalid_o    single-cycle strobe marking rdata_o valid
//   clr_done_o  pulse on the first RUN cycle after a sweep
module param_ram #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 6,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                r_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                clr_done_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam state_e StReset = CLEAR_ON_RESET ? StClear : StRun;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_last;
  logic              clr_done_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [DATA_W-1:0] mem_q [Depth];

  // Clear wins over a same-cycle request.
  assign ready_o = (state_q == StRun) && !clear_i;
  assign wr_acc  = en_i && ready_o && !r_i;
  assign rd_acc  = en_i && ready_o && r_i;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_last = 1'b0;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d  = StRun;
          ptr_d    = '0;
          clr_last = 1'b1;
        end
      end
      StRun: begin
        if (clear_i) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StReset;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StReset;
      ptr_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_done_q <= clr_last;
    end
  end

  // Storage is deliberately not reset; only the sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_W-1:0] pipe_data_q;
    logic              pipe_valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        pipe_data_q  <= '0;
        pipe_valid_q <= 1'b0;
        rdata_q      <= '0;
        rvalid_q     <= 1'b0;
      end else begin
        pipe_valid_q <= rd_acc;
        if (rd_acc) begin
          pipe_data_q <= mem_q[addr_i];
        end
        rvalid_q <= pipe_valid_q;
        if (pipe_valid_q) begin
          rdata_q <= pipe_data_q;
        end
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) begin
          rdata_q <= mem_q[addr_i];
        end
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign clr_done_o = clr_done_q;

endmodule

// File: tb/tb_param_ram.sv
module tb_param_ram;

  logic clk;
  int   n_vec;
  int   n_err;
  int   cnt;

  // Instance A: DATA_W=16, ADDR_W=4, OUT_REG=0, CLEAR_ON_RESET=1
  logic        rst, en, rd, clear;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready, rvalid, clr_done;
  logic [15:0] rdata;

  // Instance B: DATA_W=8, ADDR_W=6, OUT_REG=1, CLEAR_ON_RESET=0
  logic        b_rst, b_en, b_rd, b_clear;
  logic [5:0]  b_addr;
  logic [7:0]  b_wdata;
  logic [0:0]  b_be;
  logic        b_ready, b_rvalid, b_clr_done;
  logic [7:0]  b_rdata;

  param_ram #(
    .DATA_W(16), .ADDR_W(4), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst), .en_i(en), .r_i(rd), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .clear_i(clear), .ready_o(ready), .rdata_o(rdata), .rvalid_o(rvalid),
    .clr_done_o(clr_done)
  );

  param_ram #(
    .DATA_W(8), .ADDR_W(6), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b0)
  ) u_dut_b (
    .clk_i(clk), .reset_i(b_rst), .en_i(b_en), .r_i(b_rd), .addr_i(b_addr),
    .wdata_i(b_wdata), .be_i(b_be), .clear_i(b_clear), .ready_o(b_ready),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .clr_done_o(b_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; rd = 1'b0; clear = 1'b0; addr = '0; wdata = '0; be = '0;
    b_rst = 1'b1; b_en = 1'b0; b_rd = 1'b0; b_clear = 1'b0; b_addr = '0;
    b_wdata = '0; b_be = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);

    // Test 1: sweep after reset, then all addresses read zero
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("t1_sweep_len", 32'(cnt), 32'd16);
    chk("t1_clr_done", 32'(clr_done), 32'd1);
    en = 1'b1; rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      if (i == 0) chk("t1_clr_done_pulse", 32'(clr_done), 32'd0);
      chk("t1_rvalid", 32'(rvalid), 32'd1);
      chk("t1_rdata", 32'(rdata), 32'h0000);
    end
    en = 1'b0;
    tick();
    chk("t1_rvalid_off", 32'(rvalid), 32'd0);

    // Test 2: byte-enable merge
    en = 1'b1; rd = 1'b0; addr = 4'd3; wdata = 16'hBEEF; be = 2'b11;
    tick();
    wdata = 16'h1234; be = 2'b01;
    tick();
    chk("t2_rvalid_wr", 32'(rvalid), 32'd0);
    rd = 1'b1;
    tick();
    chk("t2_rvalid", 32'(rvalid), 32'd1);
    chk("t2_rdata", 32'(rdata), 32'hBE34);
    en = 1'b0;
    tick();
    chk("t2_rvalid_one", 32'(rvalid), 32'd0);
    chk("t2_rdata_hold", 32'(rdata), 32'hBE34);

    // Test 3: back-to-back writes then reads
    en = 1'b1; rd = 1'b0; be = 2'b11;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      wdata = 16'(i * 16'h1111);
      tick();
    end
    chk("t3_rdata_hold_wr", 32'(rdata), 32'hBE34);
    chk("t3_rvalid_wr", 32'(rvalid), 32'd0);
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      chk("t3_rvalid", 32'(rvalid), 32'd1);
      chk("t3_rdata", 32'(rdata), 32'(i * 16'h1111));
    end
    en = 1'b0;
    tick();
    chk("t3_rvalid_off", 32'(rvalid), 32'd0);
    chk("t3_rdata_hold", 32'(rdata), 32'hFFFF);

    // Test 4: clear with same-cycle write; clear during sweep is ignored
    en = 1'b1; rd = 1'b0; addr = 4'd5; wdata = 16'hAAAA; be = 2'b11; clear = 1'b1;
    #1;
    chk("t4_ready_comb", 32'(ready), 32'd0);
    tick();
    en = 1'b0; clear = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      clear = (cnt == 5);
      tick();
    end
    clear = 1'b0;
    chk("t4_sweep_len", 32'(cnt), 32'd16);
    chk("t4_clr_done", 32'(clr_done), 32'd1);
    en = 1'b1; rd = 1'b1; addr = 4'd5;
    tick();
    chk("t4_rdata5", 32'(rdata), 32'h0000);
    addr = 4'd7;
    tick();
    chk("t4_rdata7", 32'(rdata), 32'h0000);
    chk("t4_rvalid", 32'(rvalid), 32'd1);

    // Test 5: reset mid-sweep restarts the full sweep
    rd = 1'b0; addr = 4'd2; wdata = 16'h1357;
    tick();
    rd = 1'b1;
    tick();
    chk("t5_pre_rdata", 32'(rdata), 32'h1357);
    en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_rdata", 32'(rdata), 32'h0000);
    chk("t5_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t5_rst_ready", 32'(ready), 32'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("t5_sweep_len", 32'(cnt), 32'd16);
    chk("t5_clr_done", 32'(clr_done), 32'd1);
    en = 1'b1; rd = 1'b1; addr = 4'd2;
    tick();
    chk("t5_rdata2", 32'(rdata), 32'h0000);
    en = 1'b0;

    // Test 6: OUT_REG=1, no clear on reset
    b_rst = 1'b0;
    chk("t6_ready", 32'(b_ready), 32'd1);
    b_en = 1'b1; b_rd = 1'b0; b_addr = 6'd9; b_wdata = 8'h5A; b_be = 1'b1;
    tick();
    b_rd = 1'b1;
    tick();
    chk("t6_rvalid_early", 32'(b_rvalid), 32'd0);
    b_en = 1'b0;
    tick();
    chk("t6_rvalid", 32'(b_rvalid), 32'd1);
    chk("t6_rdata", 32'(b_rdata), 32'h5A);
    tick();
    chk("t6_rvalid_off", 32'(b_rvalid), 32'd0);
    chk("t6_rdata_hold", 32'(b_rdata), 32'h5A);
    chk("t6_clr_done", 32'(b_clr_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
